// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the PCI bus arbiter.
// Parking is selected by the PCI_ARB_PARK_EN macro in pci_arbiter.
package pci_arb_pkg;

  localparam int NUM_MASTERS   = 4;
  localparam int GRANT_TIMEOUT = 16;
  localparam int IDX_W         = $clog2(NUM_MASTERS);
  localparam int TMR_W         = $clog2(GRANT_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_BUSY,
    ST_TURN
  } arb_state_t;

  // Active-low one-hot grant vector for a single master.
  function automatic logic [NUM_MASTERS-1:0] gnt_low(input logic [IDX_W-1:0] idx);
    gnt_low      = '1;
    gnt_low[idx] = 1'b0;
  endfunction

endpackage

// File: rtl/pci_rr_picker.sv
// Round-robin winner search starting one past the last granted master.
// Latency: combinational; backpressure: none.
module pci_rr_picker
  import pci_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_idx,
  output logic                   pick_vld,
  output logic [IDX_W-1:0]       pick_idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last_idx;
    cand     = '0;
    // The last iteration wraps back to last_idx itself, so it has lowest priority.
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = last_idx + IDX_W'(i);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

endmodule

// File: rtl/pci_arbiter.sv
// Four-master PCI bus arbiter (IDLE/GRANT/BUSY/TURN), registered active-low grants.
// Latency: grant one cycle after IDLE samples a request; optional parking via PCI_ARB_PARK_EN.
module pci_arbiter
  import pci_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_,
  input  logic [3:0] REQ_,
  input  logic       FRAME_,
  input  logic       IRDY_,
  output logic [3:0] GNT_,
  output logic [1:0] gnt_idx,
  output logic       bus_busy
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GRANT_TIMEOUT - 1);

  arb_state_t       state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [3:0]       gnt_nxt;
  logic             frame_q;
  logic             bus_idle;
  logic             frame_fall;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;

  assign bus_idle   = FRAME_ & IRDY_;
  assign frame_fall = frame_q & ~FRAME_;

  pci_rr_picker u_picker (
    .req      (~REQ_),
    .last_idx (gnt_idx),
    .pick_vld (pick_vld),
    .pick_idx (pick_idx)
  );

`ifdef PCI_ARB_PARK_EN
  logic parked;
  // In IDLE the only way a grant line can be low is the parked grant.
  assign parked = ~&GNT_;
`endif

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    idx_nxt   = gnt_idx;
    case (state)
      ST_IDLE: begin
        if (pick_vld && bus_idle) begin
`ifdef PCI_ARB_PARK_EN
          if (parked && (pick_idx != gnt_idx)) begin
            state_nxt = ST_TURN;
          end else begin
            state_nxt = ST_GRANT;
            idx_nxt   = pick_idx;
            timer_nxt = '0;
          end
`else
          state_nxt = ST_GRANT;
          idx_nxt   = pick_idx;
          timer_nxt = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (frame_fall) begin
          state_nxt = ST_BUSY;
        end else if (REQ_[gnt_idx] || (timer == TMR_LAST)) begin
          state_nxt = ST_TURN;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      ST_BUSY: begin
        if (bus_idle) begin
          state_nxt = ST_TURN;
        end
      end
      ST_TURN: begin
        state_nxt = ST_IDLE;
`ifdef PCI_ARB_PARK_EN
        // Dropping a parked grant already spent its turnaround here.
        if (pick_vld && bus_idle) begin
          state_nxt = ST_GRANT;
          idx_nxt   = pick_idx;
          timer_nxt = '0;
        end
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase

    gnt_nxt = 4'hF;
    if (state_nxt == ST_GRANT) begin
      gnt_nxt = gnt_low(idx_nxt);
    end
`ifdef PCI_ARB_PARK_EN
    else if ((state_nxt == ST_IDLE) && (&REQ_)) begin
      gnt_nxt = gnt_low(idx_nxt);
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state    <= ST_IDLE;
      timer    <= '0;
      gnt_idx  <= IDX_W'(NUM_MASTERS - 1);
      GNT_     <= 4'hF;
      bus_busy <= 1'b0;
      frame_q  <= 1'b1;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      gnt_idx  <= idx_nxt;
      GNT_     <= gnt_nxt;
      bus_busy <= (state_nxt == ST_BUSY);
      frame_q  <= FRAME_;
    end
  end

endmodule
